// File: rtl/prog_counter.sv
// Loadable up/down counter with a programmable terminal value, wrap/saturate/one-shot
// run modes, a terminal-count pulse, a sticky overflow flag and a compare-match output.
module prog_counter #(
    parameter int          WIDTH   = 8,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] max_val,
    input  logic [WIDTH-1:0] cmp_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             done,
    output logic             cmp_match
);

    localparam logic [1:0] MODE_SAT  = 2'b01;
    localparam logic [1:0] MODE_ONCE = 2'b10;

    function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v,
                                               input logic [WIDTH-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    logic terminal;
    logic blocked;

    // Up-terminal uses >= so a max_val lowered below the count still terminates.
    assign terminal  = dir ? (count == '0) : (count >= max_val);
    assign blocked   = (mode == MODE_ONCE) && done;
    assign cmp_match = (count == cmp_val);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= WIDTH'(RST_VAL);
            tc    <= 1'b0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (ovf_clr)
                ovf <= 1'b0;
            if (mode != MODE_ONCE)
                done <= 1'b0;

            if (load) begin
                count <= clamp(load_val, max_val);
                done  <= 1'b0;
            end else if (en && !blocked) begin
                if (terminal) begin
                    // Set after the clear above so a coincident terminal step wins.
                    tc  <= 1'b1;
                    ovf <= 1'b1;
                    case (mode)
                        MODE_SAT:  count <= count;
                        MODE_ONCE: done  <= 1'b1;
                        default:   count <= dir ? max_val : '0;
                    endcase
                end else begin
                    count <= dir ? count - 1'b1 : count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_counter.sv
// Directed self-checking bench for prog_counter (WIDTH=8, RST_VAL=0).
module tb_prog_counter;

    logic       clk = 1'b0;
    logic       rst, load, en, dir, ovf_clr;
    logic [7:0] load_val, max_val, cmp_val;
    logic [1:0] mode;
    logic [7:0] count;
    logic       tc, ovf, done, cmp_match;

    int n_chk  = 0;
    int n_fail = 0;

    prog_counter #(.WIDTH(8), .RST_VAL(0)) dut (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en),
        .dir(dir), .mode(mode), .max_val(max_val), .cmp_val(cmp_val),
        .ovf_clr(ovf_clr), .count(count), .tc(tc), .ovf(ovf), .done(done),
        .cmp_match(cmp_match)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [7:0] c, input logic t,
                             input logic o, input logic d);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".tc"},    32'(tc),    32'(t));
        chk({tag, ".ovf"},   32'(ovf),   32'(o));
        chk({tag, ".done"},  32'(done),  32'(d));
    endtask

    initial begin
        rst = 1'b1; load = 1'b1; load_val = 8'h55; en = 1'b1; dir = 1'b0;
        mode = 2'b00; max_val = 8'hFF; cmp_val = 8'hAA; ovf_clr = 1'b0;
        tick();
        chk_state("reset", 8'h00, 1'b0, 1'b0, 1'b0);

        rst = 1'b0;
        tick();
        chk_state("load_over_en", 8'h55, 1'b0, 1'b0, 1'b0);

        // Up wrap with max_val=9
        load_val = 8'd0; max_val = 8'd9; en = 1'b0;
        tick();
        chk("upwrap.start", 32'(count), 32'd0);
        load = 1'b0; en = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk("upwrap.count", 32'(count), 32'(i));
            chk("upwrap.tc", 32'(tc), 32'd0);
        end
        tick();
        chk_state("upwrap.roll", 8'd0, 1'b1, 1'b1, 1'b0);
        tick();
        chk_state("upwrap.after", 8'd1, 1'b0, 1'b1, 1'b0);

        // Down saturate and ovf_clr
        en = 1'b0; load = 1'b1; load_val = 8'd3; dir = 1'b1; mode = 2'b01;
        tick();
        chk("dsat.load", 32'(count), 32'd3);
        load = 1'b0; en = 1'b1;
        tick(); chk_state("dsat.2", 8'd2, 1'b0, 1'b1, 1'b0);
        tick(); chk_state("dsat.1", 8'd1, 1'b0, 1'b1, 1'b0);
        tick(); chk_state("dsat.0", 8'd0, 1'b0, 1'b1, 1'b0);
        tick(); chk_state("dsat.hold1", 8'd0, 1'b1, 1'b1, 1'b0);
        tick(); chk_state("dsat.hold2", 8'd0, 1'b1, 1'b1, 1'b0);
        en = 1'b0; ovf_clr = 1'b1;
        tick(); chk_state("ovfclr.alone", 8'd0, 1'b0, 1'b0, 1'b0);
        en = 1'b1;
        tick(); chk_state("ovfclr.setwins", 8'd0, 1'b1, 1'b1, 1'b0);
        en = 1'b0; ovf_clr = 1'b0;

        // One-shot
        max_val = 8'd4; mode = 2'b10; dir = 1'b0; load = 1'b1; load_val = 8'd2;
        tick(); chk_state("once.load", 8'd2, 1'b0, 1'b1, 1'b0);
        load = 1'b0; en = 1'b1;
        tick(); chk_state("once.3", 8'd3, 1'b0, 1'b1, 1'b0);
        tick(); chk_state("once.4", 8'd4, 1'b0, 1'b1, 1'b0);
        tick(); chk_state("once.term", 8'd4, 1'b1, 1'b1, 1'b1);
        tick(); chk_state("once.blocked", 8'd4, 1'b0, 1'b1, 1'b1);
        load = 1'b1; load_val = 8'd0;
        tick(); chk_state("once.reload", 8'd0, 1'b0, 1'b1, 1'b0);
        load = 1'b0;
        tick(); chk_state("once.resume", 8'd1, 1'b0, 1'b1, 1'b0);
        load = 1'b1; load_val = 8'd4;
        tick();
        load = 1'b0;
        tick(); chk("once.done2", 32'(done), 32'd1);
        en = 1'b0; mode = 2'b00;
        tick(); chk("once.modeclr", 32'(done), 32'd0);

        // Clamp and runtime max_val change
        load = 1'b1; load_val = 8'd200; max_val = 8'd100;
        tick(); chk("clamp", 32'(count), 32'd100);
        load_val = 8'd50;
        tick(); chk("clamp.pass", 32'(count), 32'd50);
        load = 1'b0; max_val = 8'd20; en = 1'b1;
        tick(); chk_state("maxdrop", 8'd0, 1'b1, 1'b1, 1'b0);

        // Down wrap with compare
        en = 1'b0; load = 1'b1; load_val = 8'd1; max_val = 8'd7; cmp_val = 8'd7; dir = 1'b1;
        tick();
        chk("dwrap.load", 32'(count), 32'd1);
        chk("dwrap.cmp0", 32'(cmp_match), 32'd0);
        load = 1'b0; en = 1'b1;
        tick(); chk_state("dwrap.0", 8'd0, 1'b0, 1'b1, 1'b0);
        tick(); chk_state("dwrap.7", 8'd7, 1'b1, 1'b1, 1'b0);
        chk("dwrap.cmp7", 32'(cmp_match), 32'd1);
        tick(); chk_state("dwrap.6", 8'd6, 1'b0, 1'b1, 1'b0);
        chk("dwrap.cmp6", 32'(cmp_match), 32'd0);

        // max_val=0 up wrap: tc held continuously
        en = 1'b0; load = 1'b1; load_val = 8'd0; max_val = 8'd0; dir = 1'b0; mode = 2'b11;
        tick();
        load = 1'b0; en = 1'b1;
        tick(); chk_state("max0.a", 8'd0, 1'b1, 1'b1, 1'b0);
        tick(); chk_state("max0.b", 8'd0, 1'b1, 1'b1, 1'b0);

        // Full-range natural rollover, then mid-run reset
        en = 1'b0; load = 1'b1; load_val = 8'hFE; max_val = 8'hFF; mode = 2'b00;
        tick();
        load = 1'b0; en = 1'b1;
        tick(); chk("roll.ff", 32'(count), 32'hFF);
        tick(); chk_state("roll.00", 8'h00, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        tick(); chk_state("midreset", 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0; en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_counter.md
Name: prog_counter

Overview:
Parametrised loadable up/down counter. It adds a programmable terminal value, three run modes (wrap, saturate, one-shot), a terminal-count pulse, a sticky overflow flag and a compare-match output. It sits alongside the existing 8-bit loadable counter as its general-purpose replacement for timers, dividers and event counting. All state is updated on the rising edge of clk.

Parameters:
WIDTH, 8, counter width in bits (2..32).
RST_VAL, 0, value of count after reset; must be <= 2^WIDTH-1.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset, synchronous, active-high; highest priority.
load  input  1  load strobe; count <= clamp(load_val) next edge.
load_val  input  WIDTH  value to load.
en  input  1  count enable; one step per cycle while high.
dir  input  1  0 = count up, 1 = count down.
mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
max_val  input  WIDTH  terminal value for up-counting; also the reload value for down-wrap.
cmp_val  input  WIDTH  compare value.
ovf_clr  input  1  clears ovf.
count  output  WIDTH  current count (registered).
tc  output  1  registered one-cycle terminal-count pulse.
ovf  output  1  sticky overflow/underflow flag (registered).
done  output  1  one-shot finished flag (registered).
cmp_match  output  1  combinational, count == cmp_val.

Behaviour:
- Reset (rst=1 at an edge): count=RST_VAL, tc=0, ovf=0, done=0. All other inputs are ignored that cycle. Reset mid-operation aborts everything and has the same effect.
- Priority per edge: rst > load > en step > hold.
- Load: count <= (load_val > max_val) ? max_val : load_val. Load clears done and forces tc=0. en is ignored in the load cycle.
- Terminal condition, evaluated on the current count:
  - up: count >= max_val (covers max_val lowered below count at runtime).
  - down: count == 0.
- Step (en=1, no load, not blocked):
  - Non-terminal: count +1 (up) or -1 (down); tc=0 next cycle.
  - Terminal, wrap mode: up -> 0; down -> max_val.
  - Terminal, saturate mode: count holds.
  - Terminal, one-shot mode: count holds; done <= 1.
  - Any terminal step: tc=1 for exactly the following cycle, and ovf <= 1.
- Blocked: mode=10 and done=1. en steps are ignored, count holds, tc=0. Only load or rst resumes counting.
- done:
  - Only set in mode 10.
  - Cleared by load or rst.
  - Cleared on the next edge if mode != 10.
- ovf: sticky. ovf_clr=1 clears it; if a terminal step occurs in the same cycle, set wins (ovf=1).
- tc: 0 in every cycle not following a terminal step. Back-to-back terminal steps (max_val=0, en held in wrap mode) give tc held high continuously.
- dir and mode may change any cycle; they take effect on the same edge they are sampled.
- max_val=0:
  - up: every step is terminal; count stays 0 in wrap mode.
  - down: 0 wraps to 0.
- Width: all arithmetic is modulo 2^WIDTH, with no carry-out beyond ovf. max_val=2^WIDTH-1 in up-wrap gives natural rollover.
- Latency: count, tc, ovf and done reflect an input one edge later. cmp_match has zero cycles of latency relative to count.

Test Plan:
- Reset/load priority: WIDTH=8. rst=1 with load=1, load_val=0x55 -> count=0x00, flags 0. Next cycle load=1, en=1, load_val=0x55, max_val=0xFF -> count=0x55, no step.
- Up wrap: max_val=9, mode=00, dir=0, en held from 0 -> count 0..9,0,1. tc=1 only in the cycle count shows 0 after 9. ovf=1 afterwards.
- Down saturate plus ovf_clr: load 3, dir=1, mode=01, en held -> 3,2,1,0,0,0. tc pulses once per blocked step at 0. Pulse ovf_clr alone -> ovf=0. ovf_clr coincident with a terminal step -> ovf stays 1.
- One-shot: max_val=4, mode=10, load 2, en held -> 2,3,4,4. done=1 from the cycle after the step at 4; further en gives no change and tc=0. load 0 -> done=0 and counting resumes.
- Clamp/runtime max change: load_val=200, max_val=100 -> count=100. Count at 50, set max_val=20, up-wrap step -> count=0, tc=1.
- cmp_match and down wrap: cmp_val=7, max_val=7, dir=1, wrap, from 1 -> 1,0,7,6. cmp_match=1 in the same cycle count=7. tc=1 when count=7.
